img_fetch_ctrl: RTL and testbench

IMG_FETCH_CTRL -- requirements
Module: img_fetch_ctrl

---
 rtl/img_pkg.sv | 11 +
 rtl/img_fifo.sv | 50 +++++
 rtl/img_fetch_ctrl.sv | 82 ++++++++
 tb/tb_img_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types and constants for the image fetch controller and its FIFO.
package img_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } fetch_state_t;

   localparam int PROM_AW       = 16;
   localparam int IMG_BYTES_DEF = 16384;
endpackage

// File: rtl/img_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count and flush.
module img_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    data,
   output logic          valid,
   output logic [CW-1:0] count
);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign valid  = (count != '0);
   assign do_pop = pop && valid;
   // Head is forced to zero when empty so a stale entry never shows on the port.
   assign data   = valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !do_pop)      count <= count + CW'(1);
         else if (!push && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/img_fetch_ctrl.sv
// Prefetches one frame of bytes from a fixed-latency PROM into a FWFT FIFO,
// restarting from address 0 on every rising edge of the frame sync.
module img_fetch_ctrl
   import img_pkg::*;
#(
   parameter int IMG_BYTES  = IMG_BYTES_DEF,
   parameter int FIFO_DEPTH = 16,
   parameter int PROM_LAT   = 1
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               i_vs,
   input  logic               i_next,
   output logic               o_valid,
   output logic [7:0]         o_data,
   output logic               prom_ce,
   output logic [PROM_AW-1:0] prom_addr,
   input  logic [7:0]         prom_dout,
   output logic               o_underflow,
   output logic               o_busy
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 3;
   localparam logic [PROM_AW-1:0] LAST_ADDR = PROM_AW'(IMG_BYTES - 1);

   fetch_state_t        state;
   logic                vs_q;
   logic                frame_start;
   logic [PROM_LAT-1:0] ret_sr;
   logic [2:0]          inflight;
   logic [CW-1:0]       fifo_count;
   logic [SW-1:0]       occupancy;
   logic                push;
   logic                pop;

   assign frame_start = i_vs & ~vs_q;
   assign inflight    = 3'($countones(ret_sr));
   assign occupancy   = SW'(fifo_count) + SW'(inflight);
   // Credit: every issued read already owns a FIFO slot, so a return can never find it full.
   assign prom_ce     = (state == FETCH) && !frame_start && (occupancy < SW'(FIFO_DEPTH));
   assign push        = ret_sr[PROM_LAT-1] && !frame_start;
   assign pop         = i_next && o_valid && !frame_start;
   assign o_busy      = (state != IDLE);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         vs_q        <= 1'b0;
         prom_addr   <= '0;
         ret_sr      <= '0;
         o_underflow <= 1'b0;
      end else begin
         vs_q <= i_vs;
         if (frame_start) begin
            // Clearing ret_sr drops every return still owed to the previous frame.
            state       <= FETCH;
            prom_addr   <= '0;
            ret_sr      <= '0;
            o_underflow <= 1'b0;
         end else begin
            ret_sr <= (ret_sr << 1) | PROM_LAT'(prom_ce);
            if (i_next && !o_valid) o_underflow <= 1'b1;
            if (prom_ce) begin
               if (prom_addr == LAST_ADDR) state <= DONE;
               else                        prom_addr <= prom_addr + PROM_AW'(1);
            end
         end
      end
   end

   img_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (sys_clk),
      .rst       (rst),
      .flush     (frame_start),
      .push      (push),
      .push_data (prom_dout),
      .pop       (pop),
      .data      (o_data),
      .valid     (o_valid),
      .count     (fifo_count)
   );
endmodule

// File: tb/tb_img_fetch_ctrl.sv
// Bench for img_fetch_ctrl: one instance at PROM latency 1, one at latency 3,
// each fed by a PROM model and checked by a pop-order scoreboard.
module tb_img_fetch_ctrl;
   localparam int N = 16384;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, vs1, next1, valid1, ce1, unf1, busy1;
   logic [7:0]  data1, dout1;
   logic [15:0] addr1;
   logic        rst3, vs3, next3, valid3, ce3, unf3, busy3;
   logic [7:0]  data3, dout3;
   logic [15:0] addr3;

   logic [7:0]  exp1_q[$];
   logic [7:0]  exp3_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          ce_cnt1 = 0;
   logic [15:0] next_addr1 = '0;
   int          max_cnt1 = 0;

   img_fetch_ctrl #(.IMG_BYTES(N), .FIFO_DEPTH(16), .PROM_LAT(1)) dut1 (
      .sys_clk(clk), .rst(rst1), .i_vs(vs1), .i_next(next1), .o_valid(valid1),
      .o_data(data1), .prom_ce(ce1), .prom_addr(addr1), .prom_dout(dout1),
      .o_underflow(unf1), .o_busy(busy1));

   img_fetch_ctrl #(.IMG_BYTES(N), .FIFO_DEPTH(16), .PROM_LAT(3)) dut3 (
      .sys_clk(clk), .rst(rst3), .i_vs(vs3), .i_next(next3), .o_valid(valid3),
      .o_data(data3), .prom_ce(ce3), .prom_addr(addr3), .prom_dout(dout3),
      .o_underflow(unf3), .o_busy(busy3));

   function automatic logic [7:0] prom_byte(input logic [15:0] a);
      return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5A;
   endfunction

   // PROM models: data for the address presented in a cycle appears PROM_LAT cycles later.
   logic [7:0] p1;
   logic [7:0] p3 [3];
   always @(posedge clk) begin
      p1    <= prom_byte(addr1);
      p3[0] <= prom_byte(addr3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign dout1 = p1;
   assign dout3 = p3[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame1();
      vs1 = 1'b0; next1 = 1'b0;
      tick(1);
      vs1 = 1'b1;
      exp1_q.delete();
      for (int a = 0; a < N; a++) exp1_q.push_back(prom_byte(16'(a)));
      ce_cnt1 = 0; next_addr1 = '0;
      tick(1);
   endtask

   task automatic start_frame3();
      vs3 = 1'b1; next3 = 1'b0;
      exp3_q.delete();
      for (int a = 0; a < N; a++) exp3_q.push_back(prom_byte(16'(a)));
      tick(1);
   endtask

   // Monitors sample 1 ns before each rising edge.
   always @(negedge clk) begin
      #4;
      if (!rst1) begin
         if (ce1) begin
            check("prom_addr1", addr1, next_addr1);
            next_addr1++;
            ce_cnt1++;
         end
         if (valid1 && next1) begin
            if (exp1_q.size() == 0) check("pop1_extra", 1, 0);
            else check("pop1_data", data1, exp1_q.pop_front());
         end
         if (int'(dut1.u_fifo.count) > max_cnt1) max_cnt1 = int'(dut1.u_fifo.count);
      end
      if (!rst3 && valid3 && next3) begin
         if (exp3_q.size() == 0) check("pop3_extra", 1, 0);
         else check("pop3_data", data3, exp3_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst1 = 1'b1; vs1 = 1'b0; next1 = 1'b0;
      rst3 = 1'b1; vs3 = 1'b0; next3 = 1'b0;
      tick(3);
      check("rst_ce", ce1, 0);
      check("rst_addr", addr1, 0);
      check("rst_valid", valid1, 0);
      check("rst_data", data1, 0);
      check("rst_unf", unf1, 0);
      check("rst_busy", busy1, 0);
      check("rst3_ce", ce3, 0);
      rst1 = 1'b0; rst3 = 1'b0;
      tick(2);

      // Fill: 16 reads then stall with the first byte at the head.
      start_frame1();
      tick(40);
      check("fill_ce_count", ce_cnt1, 16);
      check("fill_ce_idle", ce1, 0);
      check("fill_valid", valid1, 1);
      check("fill_head", data1, prom_byte(16'd0));
      check("fill_busy", busy1, 1);

      // Streaming: pop every cycle from the first valid byte to the end of frame.
      start_frame1();
      t = 0;
      while (!valid1 && t < 50) begin tick(1); t++; end
      check("stream_first_valid", valid1, 1);
      next1 = 1'b1;
      tick(N);
      next1 = 1'b0;
      tick(3);
      check("stream_unf", unf1, 0);
      check("stream_done_valid", valid1, 0);
      check("stream_done_busy", busy1, 1);
      check("stream_done_ce", ce1, 0);
      check("stream_last_addr", addr1, N - 1);
      check("stream_ce_count", ce_cnt1, N);
      check("stream_q_empty", exp1_q.size(), 0);

      // Underflow: sticky until the next frame start.
      next1 = 1'b1;
      tick(1);
      next1 = 1'b0;
      check("unf_set", unf1, 1);
      tick(5);
      check("unf_sticky", unf1, 1);
      check("done_stays_empty", valid1, 0);
      start_frame1();
      check("unf_cleared", unf1, 0);

      // Full boundary: fill, then toggle pops around the 15+1 credit point.
      tick(30);
      max_cnt1 = 0;
      for (int i = 0; i < 40; i++) begin
         next1 = (i % 2 == 0);
         tick(1);
      end
      next1 = 1'b0;
      check("full_reached", max_cnt1, 16);
      check("full_not_exceeded", max_cnt1 <= 16, 1);
      check("full_unf", unf1, 0);

      // Reset mid-fetch: outputs clear immediately, nothing until a new edge.
      next1 = 1'b1;
      tick(3);
      next1 = 1'b0;
      rst1 = 1'b1;
      #1;
      check("midrst_ce", ce1, 0);
      check("midrst_addr", addr1, 0);
      check("midrst_valid", valid1, 0);
      check("midrst_data", data1, 0);
      check("midrst_unf", unf1, 0);
      check("midrst_busy", busy1, 0);
      vs1 = 1'b0;
      tick(2);
      rst1 = 1'b0;
      exp1_q.delete();
      ce_cnt1 = 0; next_addr1 = '0;
      tick(20);
      check("postrst_no_ce", ce_cnt1, 0);
      check("postrst_idle", busy1, 0);
      start_frame1();
      tick(5);
      check("postrst_ce_after_vs", ce_cnt1 > 0, 1);
      check("postrst_busy", busy1, 1);

      // Restart at address 100 with three-cycle PROM latency.
      start_frame3();
      t = 0;
      while (!valid3 && t < 50) begin tick(1); t++; end
      check("lat3_first_valid", valid3, 1);
      next3 = 1'b1;
      t = 0;
      while (!(ce3 && addr3 == 16'd100) && t < 500) begin tick(1); t++; end
      check("lat3_reach_addr100", ce3 && addr3 == 16'd100, 1);
      tick(1);
      check("lat3_read_inflight", ce3, 1);
      vs3 = 1'b0;
      tick(1);
      start_frame3();
      t = 0;
      while (!valid3 && t < 50) begin tick(1); t++; end
      check("restart_valid", valid3, 1);
      check("restart_head", data3, prom_byte(16'd0));
      check("restart_busy", busy3, 1);
      next3 = 1'b1;
      tick(50);
      next3 = 1'b0;
      tick(2);
      check("restart_unf", unf3, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
